fazyrv_rf_seq: RTL and testbench

- Sequencer for the shift-register register file. The register file is a bank of RFREGS 32-bit shiftable registers, each shifting one CHUNKSIZE-bit chunk per enabled cycle.
- On a start request it latches rs1/rs2/rd and drives per-register shift enables for exactly 32/CHUNKSIZE cycles, so the datapath streams rs1/rs2 chunks LSB-first and optionally writes rd.
- Read registers recirculate their own output, so they hold their value after a full rotation. The write register takes core write data instead.
- Sits between the core control FSM and the register bank. It holds no data itself.

---
 rtl/fazyrv_rf_seq_if.sv | 44 ++++
 rtl/fazyrv_rf_seq.sv | 129 ++++++++++++
 tb/tb_fazyrv_rf_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fazyrv_rf_seq_if.sv
// Control bundle between the core control FSM and the register-file sequencer.
// master: core side (issues start/addresses, observes pass progress).
// slave : sequencer side (consumes the request, drives shift/write selects).
//   start_i, rs1_i, rs2_i, rd_i, we_i   pass request
//   busy_o, last_o, done_o, cnt_o        pass progress
//   shft_o, wsel_o                       per-register shift / write-select
//   rs1_sel_o, rs2_sel_o, rs*_zero_o     latched read-mux controls
interface fazyrv_rf_seq_if #(
    parameter int unsigned CHUNKSIZE = 2,
    parameter int unsigned RFREGS    = 32
);
    localparam int unsigned AW     = $clog2(RFREGS);
    localparam int unsigned NCHUNK = 32 / CHUNKSIZE;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic              start_i;
    logic [AW-1:0]     rs1_i;
    logic [AW-1:0]     rs2_i;
    logic [AW-1:0]     rd_i;
    logic              we_i;

    logic              busy_o;
    logic              last_o;
    logic              done_o;
    logic [CW-1:0]     cnt_o;
    logic [RFREGS-1:0] shft_o;
    logic [RFREGS-1:0] wsel_o;
    logic [AW-1:0]     rs1_sel_o;
    logic [AW-1:0]     rs2_sel_o;
    logic              rs1_zero_o;
    logic              rs2_zero_o;

    modport master (
        output start_i, rs1_i, rs2_i, rd_i, we_i,
        input  busy_o, last_o, done_o, cnt_o, shft_o, wsel_o,
               rs1_sel_o, rs2_sel_o, rs1_zero_o, rs2_zero_o
    );

    modport slave (
        input  start_i, rs1_i, rs2_i, rd_i, we_i,
        output busy_o, last_o, done_o, cnt_o, shft_o, wsel_o,
               rs1_sel_o, rs2_sel_o, rs1_zero_o, rs2_zero_o
    );
endinterface

// File: rtl/fazyrv_rf_seq.sv
// Register-file pass sequencer: on start it latches rs1/rs2/rd and drives the
// per-register shift enables for 32/CHUNKSIZE cycles so the shift-register bank
// rotates one chunk per cycle (reads recirculate, rd takes write data).
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   rf     fazyrv_rf_seq_if.slave (request in, pass controls out)
// Every output is a flop; nothing on rf.*_i reaches an output combinationally.
module fazyrv_rf_seq #(
    parameter int unsigned CHUNKSIZE = 2,
    parameter int unsigned RFREGS    = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    fazyrv_rf_seq_if.slave  rf
);
    localparam int unsigned AW     = $clog2(RFREGS);
    localparam int unsigned NCHUNK = 32 / CHUNKSIZE;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [RFREGS-1:0] shft_q, shft_d;
    logic [RFREGS-1:0] wsel_q, wsel_d;
    logic [AW-1:0]     rs1_q, rs1_d;
    logic [AW-1:0]     rs2_q, rs2_d;
    logic              rs1z_q, rs1z_d;
    logic              rs2z_q, rs2z_d;

    function automatic logic [RFREGS-1:0] onehot(input logic [AW-1:0] a);
        return RFREGS'(1) << a;
    endfunction

    // State and latched pass controls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            shft_q  <= '0;
            wsel_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rs1z_q  <= 1'b0;
            rs2z_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            done_q  <= done_d;
            shft_q  <= shft_d;
            wsel_q  <= wsel_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rs1z_q  <= rs1z_d;
            rs2z_q  <= rs2z_d;
        end
    end

    // Next state; shift/write selects are fixed for a whole pass, so they are
    // computed once at start and held until the final chunk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = 1'b0;
        done_d  = 1'b0;
        shft_d  = shft_q;
        wsel_d  = wsel_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rs1z_d  = rs1z_q;
        rs2z_d  = rs2z_q;

        case (state_q)
            IDLE: begin
                shft_d = '0;
                wsel_d = '0;
                if (rf.start_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    last_d  = (CNT_LAST == '0);
                    rs1_d   = rf.rs1_i;
                    rs2_d   = rf.rs2_i;
                    rs1z_d  = (rf.rs1_i == '0);
                    rs2z_d  = (rf.rs2_i == '0);
                    // OR of one-hots: aliased registers shift once; x0 never shifts
                    shft_d  = (onehot(rf.rs1_i) | onehot(rf.rs2_i) |
                               (rf.we_i ? onehot(rf.rd_i) : '0)) & ~RFREGS'(1);
                    wsel_d  = (rf.we_i && (rf.rd_i != '0)) ? onehot(rf.rd_i) : '0;
                end
            end
            RUN: begin
                if (last_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    shft_d  = '0;
                    wsel_d  = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    last_d  = ((cnt_q + CW'(1)) == CNT_LAST);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rf.busy_o     = (state_q == RUN);
    assign rf.last_o     = last_q;
    assign rf.done_o     = done_q;
    assign rf.cnt_o      = cnt_q;
    assign rf.shft_o     = shft_q;
    assign rf.wsel_o     = wsel_q;
    assign rf.rs1_sel_o  = rs1_q;
    assign rf.rs2_sel_o  = rs2_q;
    assign rf.rs1_zero_o = rs1z_q;
    assign rf.rs2_zero_o = rs2z_q;
endmodule

// File: tb/tb_fazyrv_rf_seq.sv
// Scoreboard bench for fazyrv_rf_seq: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares whenever busy_o/done_o is presented.
// A behavioural shift-register bank is driven from shft_o/wsel_o.
module tb_fazyrv_rf_seq;
    localparam int unsigned CS = 2;
    localparam int unsigned RF = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned N  = 16;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic sw_start;
    logic init_req;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fazyrv_rf_seq_if #(.CHUNKSIZE(CS), .RFREGS(RF)) bus ();
    fazyrv_rf_seq #(.CHUNKSIZE(CS), .RFREGS(RF)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rf    (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return {8'(i), 8'hA5, 8'(i * 7 + 1), 8'h3C};
    endfunction

    // ---------------- register bank model ----------------
    logic [31:0] regs [RF];
    logic [31:0] rd1_stream;
    logic [31:0] wdata = 32'hC0DE_5A17;

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < int'(RF); i++) regs[i] <= init_val(i);
        end else if (bus.busy_o === 1'b1) begin
            rd1_stream[bus.cnt_o*CS +: CS] <= bus.rs1_zero_o ? 2'b00 : regs[bus.rs1_sel_o][CS-1:0];
            for (int i = 0; i < int'(RF); i++)
                if (bus.shft_o[i])
                    regs[i] <= {bus.wsel_o[i] ? wdata[bus.cnt_o*CS +: CS] : regs[i][CS-1:0],
                                regs[i][31:CS]};
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int            at;
        logic          done;
        logic [CW-1:0] cnt;
        logic          last;
        logic [RF-1:0] shft;
        logic [RF-1:0] wsel;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          z1;
        logic          z2;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic pres;

    always @(negedge clk) begin
        pres = (bus.busy_o === 1'b1) || (bus.done_o === 1'b1);
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            n_chk++;
            n_err++;
            $display("FAIL missing_output due=%0d now=%0d", e.at, cyc);
        end
        if (pres) begin
            if (sb.size() == 0 || sb[0].at != cyc) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_output busy=%0b done=%0b cnt=%0d cycle=%0d",
                         bus.busy_o, bus.done_o, bus.cnt_o, cyc);
            end else begin
                e = sb.pop_front();
                chk("mon_busy", 64'(bus.busy_o), 64'(!e.done));
                chk("mon_done", 64'(bus.done_o), 64'(e.done));
                chk("mon_cnt",  64'(bus.cnt_o),  64'(e.cnt));
                chk("mon_last", 64'(bus.last_o), 64'(e.last));
                chk("mon_shft", 64'(bus.shft_o), 64'(e.shft));
                chk("mon_wsel", 64'(bus.wsel_o), 64'(e.wsel));
                chk("mon_rs1_sel", 64'(bus.rs1_sel_o), 64'(e.rs1));
                chk("mon_rs2_sel", 64'(bus.rs2_sel_o), 64'(e.rs2));
                chk("mon_rs1_zero", 64'(bus.rs1_zero_o), 64'(e.z1));
                chk("mon_rs2_zero", 64'(bus.rs2_zero_o), 64'(e.z2));
            end
        end else if (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            n_chk++;
            n_err++;
            $display("FAIL missing_output due=%0d now=%0d", e.at, cyc);
        end
    end

    // Issue a pass at a negedge while the DUT is idle; expectations are
    // hand-supplied shft/wsel/zero flags, one record per RUN cycle plus done.
    task automatic start_pass(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                              input logic [AW-1:0] rd, input logic we,
                              input logic [RF-1:0] xshft, input logic [RF-1:0] xwsel,
                              input logic z1, input logic z2,
                              input int nrun, input bit with_done);
        exp_t r;
        bus.rs1_i   = rs1;
        bus.rs2_i   = rs2;
        bus.rd_i    = rd;
        bus.we_i    = we;
        bus.start_i = 1'b1;
        for (int k = 0; k < nrun; k++) begin
            r.at = cyc + 1 + k; r.done = 1'b0; r.cnt = CW'(k); r.last = (k == 15);
            r.shft = xshft; r.wsel = xwsel; r.rs1 = rs1; r.rs2 = rs2; r.z1 = z1; r.z2 = z2;
            sb.push_back(r);
        end
        if (with_done) begin
            r.at = cyc + 17; r.done = 1'b1; r.cnt = '0; r.last = 1'b0;
            r.shft = '0; r.wsel = '0; r.rs1 = rs1; r.rs2 = rs2; r.z1 = z1; r.z2 = z2;
            sb.push_back(r);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) return;
        end
        n_chk++;
        n_err++;
        $display("FAIL wait_done timeout after %0d cycles", budget);
    endtask

    // ---------------- parameter sweep DUTs ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int unsigned SCS  = (g == 0) ? 1 : (g == 1) ? 4 : 8;
        localparam int unsigned SRF  = (g == 1) ? 32 : 16;
        localparam int unsigned SAW  = $clog2(SRF);
        localparam int          SLEN = (g == 0) ? 32 : (g == 1) ? 8 : 4;

        fazyrv_rf_seq_if #(.CHUNKSIZE(SCS), .RFREGS(SRF)) sif ();
        fazyrv_rf_seq #(.CHUNKSIZE(SCS), .RFREGS(SRF)) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .rf    (sif)
        );

        assign sif.start_i = sw_start;
        assign sif.rs1_i   = SAW'(3);
        assign sif.rs2_i   = SAW'(5);
        assign sif.rd_i    = '0;
        assign sif.we_i    = 1'b0;

        int run_len   = 0;
        bit done_seen = 1'b0;

        always @(negedge clk) begin
            if (sif.busy_o === 1'b1) begin
                chk("sw_cnt",  64'(sif.cnt_o),  64'(run_len));
                chk("sw_last", 64'(sif.last_o), 64'(run_len == SLEN - 1));
                chk("sw_shft", 64'(sif.shft_o), 64'h28);
                run_len++;
            end
            if (sif.done_o === 1'b1) begin
                chk("sw_len", 64'(run_len), 64'(SLEN));
                run_len   = 0;
                done_seen = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bool_found_init();
    end

    task automatic bool_found_init();
        bit found;
        rst = 1'b1; sw_start = 1'b0; init_req = 1'b1;
        bus.start_i = 1'b0; bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_i = '0; bus.we_i = 1'b0;
        repeat (3) @(negedge clk);
        init_req = 1'b0;

        chk("rst_busy", 64'(bus.busy_o), 0);
        chk("rst_last", 64'(bus.last_o), 0);
        chk("rst_done", 64'(bus.done_o), 0);
        chk("rst_cnt",  64'(bus.cnt_o),  0);
        chk("rst_shft", 64'(bus.shft_o), 0);
        chk("rst_wsel", 64'(bus.wsel_o), 0);
        chk("rst_rs1_sel", 64'(bus.rs1_sel_o), 0);
        chk("rst_rs2_sel", 64'(bus.rs2_sel_o), 0);
        chk("rst_rs1_zero", 64'(bus.rs1_zero_o), 0);
        chk("rst_rs2_zero", 64'(bus.rs2_zero_o), 0);
        rst = 1'b0;
        @(negedge clk);

        // basic read: rs1=3, rs2=5, no write
        start_pass(5'd3, 5'd5, 5'd0, 1'b0, 32'h28, 32'h0, 1'b0, 1'b0, 16, 1'b1);
        wait_done(40);
        chk("t1_reg3", 64'(regs[3]), 64'(init_val(3)));
        chk("t1_reg5", 64'(regs[5]), 64'(init_val(5)));
        chk("t1_rs1_stream", 64'(rd1_stream), 64'(init_val(3)));
        @(negedge clk);

        // write pass: rd=7
        start_pass(5'd1, 5'd2, 5'd7, 1'b1, 32'h86, 32'h80, 1'b0, 1'b0, 16, 1'b1);
        wait_done(40);
        chk("t2_reg7", 64'(regs[7]), 64'hC0DE_5A17);
        chk("t2_reg1", 64'(regs[1]), 64'(init_val(1)));
        chk("t2_reg2", 64'(regs[2]), 64'(init_val(2)));
        chk("t2_rs1_stream", 64'(rd1_stream), 64'(init_val(1)));
        @(negedge clk);

        // zero registers everywhere
        start_pass(5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 16, 1'b1);
        wait_done(40);
        chk("t3_reg0", 64'(regs[0]), 64'(init_val(0)));
        chk("t3_rs1_stream", 64'(rd1_stream), 0);
        @(negedge clk);

        // full aliasing plus an ignored start during RUN
        start_pass(5'd4, 5'd4, 5'd4, 1'b1, 32'h10, 32'h10, 1'b0, 1'b0, 16, 1'b1);
        repeat (2) @(negedge clk);
        bus.rs1_i = 5'd9; bus.rs2_i = 5'd9; bus.rd_i = 5'd9; bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(40);
        chk("t4_reg4", 64'(regs[4]), 64'hC0DE_5A17);
        chk("t4_rs1_stream", 64'(rd1_stream), 64'(init_val(4)));

        // back-to-back start in the done cycle, then reset at cnt_o=5
        start_pass(5'd6, 5'd0, 5'd2, 1'b1, 32'h44, 32'h04, 1'b0, 1'b1, 6, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy_o === 1'b1 && bus.cnt_o == CW'(5)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t5_reach_cnt5", 64'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_busy", 64'(bus.busy_o), 0);
        chk("t5_rst_done", 64'(bus.done_o), 0);
        chk("t5_rst_last", 64'(bus.last_o), 0);
        chk("t5_rst_cnt",  64'(bus.cnt_o),  0);
        chk("t5_rst_shft", 64'(bus.shft_o), 0);
        chk("t5_rst_wsel", 64'(bus.wsel_o), 0);
        chk("t5_rst_rs1_sel", 64'(bus.rs1_sel_o), 0);
        chk("t5_rst_rs2_zero", 64'(bus.rs2_zero_o), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // parameter sweep
        sw_start = 1'b1;
        @(negedge clk);
        sw_start = 1'b0;
        repeat (40) @(negedge clk);
        chk("sw0_done_seen", 64'(g_sw[0].done_seen), 1);
        chk("sw1_done_seen", 64'(g_sw[1].done_seen), 1);
        chk("sw2_done_seen", 64'(g_sw[2].done_seen), 1);

        chk("sb_drained", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    endtask
endmodule
